// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and duty-code type shared by the PWM generator and pwm_capture.
package pwm_pkg;
    localparam int PWM_WIDTH = 8;
    localparam int PWM_PERIOD = 256;
    localparam logic [PWM_WIDTH-1:0] PWM_CODE_MAX = 8'hFF;
    localparam logic [PWM_WIDTH-1:0] PWM_CODE_MIN = 8'h00;
    typedef logic [PWM_WIDTH-1:0] duty_t;
endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: synchronizes an asynchronous line and flags its edges.
// Ports: clk, rst_n (async active-low), pulse_in (async line),
//        p_s (synchronized level), rise / fall (single-cycle edge flags).
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic p_s,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic p_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            p_d <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pulse_in};
            p_d <= p_s;
        end
    end

    assign p_s = sync[SYNC_STAGES-1];
    assign rise = p_s & ~p_d;
    assign fall = ~p_s & p_d;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: recovers the duty code of a PWM line, flags bad periods, reports lock.
// Ports: clk, rst_n (async active-low), pulse_in (async PWM line),
//        pulse_width (recovered code, held), width_valid (update strobe),
//        period_err (bad-period strobe), locked (last period was exact).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int PERIOD = 2 ** WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] pulse_width,
    output logic             width_valid,
    output logic             period_err,
    output logic             locked
);
    localparam int CW = WIDTH + 1;
    localparam logic [CW-1:0] PER = CW'(PERIOD);
    localparam logic [CW-1:0] CODE_TOP = CW'(PERIOD - 2);
    localparam logic [CW-1:0] SAT = '1;

    logic p_s, rise, fall;
    logic [CW-1:0] high_cnt, period_cnt, idle_cnt;
    logic have_rise;
    logic any_edge, timeout, clamp;
    logic [CW-1:0] meas;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst_n(rst_n),
        .pulse_in(pulse_in),
        .p_s(p_s),
        .rise(rise),
        .fall(fall)
    );

    // high_cnt counts the rise cycle as 1, so a code-N pulse measures N+1
    assign meas = high_cnt - CW'(1);
    assign clamp = meas > CODE_TOP;
    assign any_edge = rise | fall;
    // an edge landing on the timeout cycle wins, so legal streams never time out
    assign timeout = (idle_cnt == PER) && !any_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt <= '0;
            period_cnt <= '0;
            idle_cnt <= '0;
            have_rise <= 1'b0;
            pulse_width <= '0;
            width_valid <= 1'b0;
            period_err <= 1'b0;
            locked <= 1'b0;
        end else begin
            width_valid <= 1'b0;
            period_err <= 1'b0;
            high_cnt <= rise ? CW'(1) : (p_s && high_cnt != SAT) ? high_cnt + CW'(1) : high_cnt;
            period_cnt <= rise ? CW'(1) : (period_cnt != SAT) ? period_cnt + CW'(1) : period_cnt;
            idle_cnt <= (any_edge || timeout) ? '0 : idle_cnt + CW'(1);
            if (rise) begin
                have_rise <= 1'b1;
                if (have_rise) begin
                    locked <= period_cnt == PER;
                    period_err <= period_cnt != PER;
                end
            end
            // a fall without a preceding rise is a truncated pulse and is dropped
            if (fall && have_rise) begin
                width_valid <= 1'b1;
                pulse_width <= clamp ? CODE_TOP[WIDTH-1:0] : meas[WIDTH-1:0];
                period_err <= clamp;
            end
            // stuck line: report the level as full-scale or zero duty
            if (timeout) begin
                width_valid <= 1'b1;
                pulse_width <= {WIDTH{p_s}};
                locked <= 1'b0;
                have_rise <= 1'b0;
            end
        end
    end
endmodule
